// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// the state encoding and the default conditional-branch opcode.
package hazard_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

  localparam logic [3:0] BRANCH_OP_DEF = 4'b1011;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE       = ST_IDLE,
    S_LOAD_STALL = ST_LOAD_STALL,
    S_FLUSH      = ST_FLUSH,
    S_MEM_WAIT   = ST_MEM_WAIT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, holds at all-ones.
// Ports: clock, reset (async, active-high), inc, count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: Moore FSM producing stall/bubble/flush/freeze.
// Ports: clock, reset, ID/EX hazard inputs, mem_busy; control outs,
// state_dbg and a saturating stall-cycle counter stall_count.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int OPCODE_W = 4,
  parameter logic [OPCODE_W-1:0] BRANCH_OP =
    OPCODE_W'(BRANCH_OP_DEF),
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs2,
  input  logic                   ex_memread,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic [OPCODE_W-1:0]    ex_opcode,
  input  logic                   ex_zero,
  input  logic                   mem_busy,
  output logic                   stall,
  output logic                   bubble,
  output logic                   flush,
  output logic                   freeze,
  output logic [1:0]             state_dbg,
  output logic [STALL_CNT_W-1:0] stall_count
);

  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 15) begin : g_bad_fd
    $error("FLUSH_DEPTH out of range 1..15");
  end
  if (LOAD_STALL_CYCLES < 1 ||
      LOAD_STALL_CYCLES > 15) begin : g_bad_lsc
    $error("LOAD_STALL_CYCLES out of range 1..15");
  end

  localparam logic [CNT_W-1:0] FD_RELOAD =
    CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] LS_RELOAD =
    CNT_W'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken;
  logic             hazard;
  logic             rs1_hit;
  logic             rs2_hit;

  assign taken = (ex_opcode == BRANCH_OP) && !ex_zero;

  assign rs1_hit = (ex_rd == id_rs1);
  assign rs2_hit = id_uses_rs2 && (ex_rd == id_rs2);
  assign hazard  = ex_memread && (ex_rd != '0) &&
                   (rs1_hit || rs2_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_LOAD_STALL: begin
        // A new event preempts a running load stall.
        if (mem_busy) begin
          state_d = S_MEM_WAIT;
          cnt_d   = '0;
        end else if (taken) begin
          state_d = S_FLUSH;
          cnt_d   = FD_RELOAD;
        end else if (hazard) begin
          state_d = S_LOAD_STALL;
          cnt_d   = LS_RELOAD;
        end else if (state_q == S_LOAD_STALL) begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mem_busy) begin
          state_d = S_MEM_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall = (state_q == S_LOAD_STALL) ||
                 (state_q == S_MEM_WAIT);
  assign bubble    = (state_q == S_LOAD_STALL);
  assign flush     = (state_q == S_FLUSH);
  assign freeze    = (state_q == S_MEM_WAIT);
  assign state_dbg = state_q;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (stall),
    .count(stall_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: queue-based reference model
// plus directed scenarios with literal expectations.
module tb_pipeline_hazard_controller;

  localparam int FD  = 2;
  localparam int LSC = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs1, id_rs2, ex_rd, ex_opcode;
  logic       id_uses_rs2, ex_memread, ex_zero, mem_busy;

  logic        stall, bubble, flush, freeze;
  logic [1:0]  state_dbg;
  logic [15:0] stall_count;

  logic        stall2, bubble2, flush2, freeze2;
  logic [1:0]  state_dbg2;
  logic [1:0]  stall_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clock(clk), .reset(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_zero(ex_zero),
    .mem_busy(mem_busy),
    .stall(stall), .bubble(bubble),
    .flush(flush), .freeze(freeze),
    .state_dbg(state_dbg),
    .stall_count(stall_count)
  );

  pipeline_hazard_controller #(.STALL_CNT_W(2)) dut2 (
    .clock(clk), .reset(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_zero(ex_zero),
    .mem_busy(mem_busy),
    .stall(stall2), .bubble(bubble2),
    .flush(flush2), .freeze(freeze2),
    .state_dbg(state_dbg2),
    .stall_count(stall_count2)
  );

  // Model: a queue of the outputs still planned ("L","F","M");
  // empty queue means idle. m_cnt is the unsaturated stall count.
  byte mq[$];
  int  m_cnt;

  function automatic byte head();
    return (mq.size() == 0) ? "I" : mq[0];
  endfunction

  always @(posedge clk or posedge rst) begin
    byte cur;
    bit  tk, hz;
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      cur = head();
      tk = (ex_opcode == 4'b1011) && !ex_zero;
      hz = ex_memread && ex_rd != 0 &&
           (ex_rd == id_rs1 ||
            (id_uses_rs2 && ex_rd == id_rs2));
      if (cur == "L" || cur == "M") m_cnt++;
      if (cur == "F") begin
        void'(mq.pop_front());
        if (mq.size() == 0 && mem_busy) mq.push_back("M");
      end else if (cur == "M") begin
        if (!mem_busy) mq.delete();
      end else begin
        if (mem_busy) begin
          mq.delete();
          mq.push_back("M");
        end else if (tk) begin
          mq.delete();
          repeat (FD) mq.push_back("F");
        end else if (hz) begin
          mq.delete();
          repeat (LSC) mq.push_back("L");
        end else if (cur == "L") begin
          void'(mq.pop_front());
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the edge.
  always @(negedge clk) begin
    byte h;
    int  es;
    h = head();
    es = (h == "L") ? 1 : (h == "F") ? 2 :
         (h == "M") ? 3 : 0;
    chk("m_state", state_dbg, es);
    chk("m_stall", stall, int'(h == "L" || h == "M"));
    chk("m_bubble", bubble, int'(h == "L"));
    chk("m_flush", flush, int'(h == "F"));
    chk("m_freeze", freeze, int'(h == "M"));
    chk("m_count", stall_count,
        (m_cnt > 65535) ? 65535 : m_cnt);
    chk("m_count2", stall_count2,
        (m_cnt > 3) ? 3 : m_cnt);
    chk("m_state2", state_dbg2, es);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_uses_rs2 = 1'b0;
    ex_memread = 1'b0; ex_rd = 4'd0;
    ex_opcode = 4'd0; ex_zero = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_count", stall_count, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Load-use on rs1.
    ex_memread = 1; ex_rd = 3; id_rs1 = 3;
    cyc(1);
    idle_in();
    chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble, 1);
    cyc(1);
    chk("lu_done", stall, 0);
    chk("lu_count", stall_count, 1);

    // rd = 0 never hazards.
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    cyc(1);
    chk("rd0_stall", stall, 0);
    // rs2 match only counts when rs2 is used.
    ex_rd = 5; id_rs1 = 1; id_rs2 = 5; id_uses_rs2 = 0;
    cyc(1);
    chk("rs2_unused", stall, 0);
    id_uses_rs2 = 1;
    cyc(1);
    idle_in();
    chk("rs2_used", stall, 1);
    cyc(1);

    // Taken branch flushes for two cycles.
    ex_opcode = 4'b1011; ex_zero = 0;
    cyc(1);
    idle_in();
    chk("br_f1", flush, 1);
    cyc(1);
    chk("br_f2", flush, 1);
    cyc(1);
    chk("br_f3", flush, 0);
    ex_opcode = 4'b1011; ex_zero = 1;
    cyc(1);
    idle_in();
    chk("br_nt", flush, 0);

    // Branch beats load-use; mem_busy beats both.
    ex_opcode = 4'b1011; ex_memread = 1;
    ex_rd = 7; id_rs1 = 7;
    cyc(1);
    idle_in();
    chk("pri_flush", flush, 1);
    chk("pri_nobub", bubble, 0);
    cyc(2);
    ex_opcode = 4'b1011; ex_memread = 1;
    ex_rd = 7; id_rs1 = 7; mem_busy = 1;
    cyc(1);
    idle_in();
    chk("pri_mw", state_dbg, 3);
    cyc(1);
    chk("pri_idle", state_dbg, 0);

    // Hazard during FLUSH is ignored, re-presented after.
    ex_opcode = 4'b1011;
    cyc(1);
    ex_opcode = 0; ex_memread = 1; ex_rd = 2; id_rs1 = 2;
    cyc(1);
    chk("ign_flush", flush, 1);
    cyc(1);
    chk("ign_idle", state_dbg, 0);
    cyc(1);
    idle_in();
    chk("ign_stall", bubble, 1);
    cyc(1);

    // Memory wait: five cycles.
    do_reset();
    mem_busy = 1;
    cyc(1);
    chk("mw_freeze", freeze, 1);
    cyc(4);
    chk("mw_stall5", stall, 1);
    mem_busy = 0;
    cyc(1);
    chk("mw_done", stall, 0);
    chk("mw_count", stall_count, 5);

    // Six-cycle stall saturates the 2-bit counter.
    do_reset();
    mem_busy = 1;
    cyc(6);
    mem_busy = 0;
    cyc(1);
    chk("sat_wide", stall_count, 6);
    chk("sat_narrow", stall_count2, 3);
    cyc(2);
    chk("sat_hold", stall_count2, 3);

    // Reset in first FLUSH cycle.
    ex_opcode = 4'b1011;
    cyc(1);
    idle_in();
    chk("rf_pre", flush, 1);
    rst = 1'b1;
    #1;
    chk("rf_flush0", flush, 0);
    chk("rf_state0", state_dbg, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("rf_idle", state_dbg, 0);
    chk("rf_noflush", flush, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter REG_ADDR_W, default 4: register-address width.
REQ-002 Parameter OPCODE_W, default 4: opcode width.
REQ-003 Parameter BRANCH_OP, default 4'b1011: opcode of the conditional branch; taken when ex_zero==0.
REQ-004 Parameter FLUSH_DEPTH, default 2: cycles flush stays asserted per taken branch; legal range 1..15.
REQ-005 Parameter LOAD_STALL_CYCLES, default 1: bubble cycles per load-use hazard; legal range 1..15.
REQ-006 Parameter STALL_CNT_W, default 16: width of the stall performance counter.
REQ-007 clock  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
REQ-010 id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
REQ-011 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-012 ex_memread  in  1  EX instruction is a load.
REQ-013 ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
REQ-014 ex_opcode  in  OPCODE_W  opcode of the EX instruction.
REQ-015 ex_zero  in  1  ALU zero flag of the EX instruction.
REQ-016 mem_busy  in  1  data memory not ready this cycle.
REQ-017 stall  out  1  hold PC and IF/ID.
REQ-018 bubble  out  1  load NOP into ID/EX.
REQ-019 flush  out  1  clear IF/ID and ID/EX.
REQ-020 freeze  out  1  hold EX/MEM and MEM/WB.
REQ-021 state_dbg  out  2  encoded current state.
REQ-022 stall_count  out  STALL_CNT_W  cycles in which stall==1.

Function
REQ-023 Four states, encoded IDLE=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3; all outputs are a Moore decode of the state register, so latency is one cycle from a sampled condition to its output.
REQ-024 The decode is: IDLE gives all outputs 0; LOAD_STALL gives stall=1, bubble=1; FLUSH gives flush=1; MEM_WAIT gives stall=1, freeze=1.
REQ-025 taken = (ex_opcode==BRANCH_OP) && !ex_zero.
REQ-026 hazard = ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
REQ-027 From IDLE or LOAD_STALL, evaluate in priority order: mem_busy goes to MEM_WAIT; else taken goes to FLUSH with cnt=FLUSH_DEPTH-1; else hazard goes to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
REQ-028 If none of these conditions holds, IDLE stays in IDLE, and LOAD_STALL goes to IDLE when cnt==0 or decrements cnt otherwise.
REQ-029 FLUSH is not interruptible: while cnt!=0, decrement cnt; when cnt==0, go to MEM_WAIT if mem_busy, else IDLE.
REQ-030 MEM_WAIT remains while mem_busy==1 and goes to IDLE on the first cycle mem_busy==0.
REQ-031 A hazard sampled in MEM_WAIT or FLUSH is ignored; ID re-presents it after return to IDLE.
REQ-032 stall_count increments each cycle stall==1 and saturates at all-ones (no wrap).
REQ-033 cnt is 4 bits.
REQ-034 A parameter outside its legal range is an elaboration error.

Reset
REQ-035 While reset==1: state=IDLE, cnt=0, stall_count=0, and all outputs are 0, asynchronously.
REQ-036 Reset asserted mid-LOAD_STALL, mid-FLUSH or mid-MEM_WAIT abandons the pending sequence entirely.
REQ-037 The first state update occurs on the first rising clock edge after reset deasserts.

Structure
REQ-038 State encoding localparams and the default BRANCH_OP reside in a shared package, hazard_pkg.
REQ-039 The saturating counter is sub-module sat_counter (parameter W; ports clock, reset, inc, count).
REQ-040 There are no other sub-modules.

Verification
REQ-041 Load-use: ex_memread=1, ex_rd=3, id_rs1=3, defaults -> exactly one cycle stall=bubble=1 starting next cycle, then IDLE; stall_count=1.
REQ-042 rd=0 and rs2-only cases: ex_rd=0=id_rs1 gives no stall; ex_rd=5=id_rs2 with id_uses_rs2=0 gives no stall, and with id_uses_rs2=1 gives a stall.
REQ-043 Branch: ex_opcode=4'b1011, ex_zero=0 -> flush=1 for 2 cycles; with ex_zero=1 -> no flush.
REQ-044 Priority: taken branch and load-use hazard in the same cycle -> FLUSH, no bubble; mem_busy also high in that cycle -> MEM_WAIT.
REQ-045 Memory wait: mem_busy high for 5 cycles -> stall=freeze=1 for 5 cycles; stall_count=5; with STALL_CNT_W=2, a 6-cycle stall holds stall_count at 3.
REQ-046 Reset in the first FLUSH cycle -> outputs 0 immediately; IDLE after release.
